bcd_subtractor_4digits_seq: RTL and testbench
=============================================

BCD_SUBTRACTOR_4DIGITS_SEQ -- requirements
Module: bcd_subtractor_4digits_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock; all state SHALL change on this edge except reset.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 a  input  16  minuend, 4 packed BCD digits, [3:0] least significant.
REQ-006 b  input  16  subtrahend, 4 packed BCD digits.
REQ-007 bin  input  1  borrow-in, subtracted at digit 0.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse when diff, bout, neg and err are valid.
REQ-010 diff  output  16  BCD result.
REQ-011 bout  output  1  borrow-out from digit 3.
REQ-012 neg  output  1  result-is-negative flag (see Configuration).
REQ-013 err  output  1  high if any latched operand digit exceeded 9.

Function
REQ-014 FSM states SHALL be IDLE, SUB, NEG, DONE; NEG exists only with BCD_SUB_MAGNITUDE_EN.
REQ-015 In IDLE with start=1: latch a, b, bin, clear diff, set digit index to 0, compute err from the latched operands, go to SUB.
REQ-016 In SUB, one digit per cycle: t = a_i - b_i - borrow; if t<0 then d_i = t+10 and borrow=1, else d_i = t and borrow=0; borrow for digit 0 = bin.
REQ-017 d_i SHALL be truncated to 4 bits; invalid digits (>9) SHALL be processed by the same formula without trapping.
REQ-018 After digit 3, bout SHALL equal the final borrow; next state SHALL be DONE (or NEG, per REQ-027).
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: start sampled at edge k -> done high in the cycle after edge k+4 (5 edges), excluding NEG.
REQ-021 busy SHALL be 1 in SUB and NEG and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored in SUB, NEG and DONE; no queuing.
REQ-023 a, b and bin changes after latching SHALL NOT affect the operation in progress.
REQ-024 diff, bout, neg and err SHALL hold their values from done until the next accepted start.

Reset
REQ-025 On rst_n=0, at any time including mid-operation: state=IDLE, diff=16'h0000, bout=0, neg=0, err=0, busy=0, done=0, and internal index and borrow cleared; a partial result SHALL be discarded.
REQ-026 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-027 With BCD_SUB_MAGNITUDE_EN defined: if bout=1 after SUB, the FSM SHALL enter NEG and run 4 more digit cycles computing 0000 - diff with borrow-in 0 using REQ-016.
REQ-028 In that case diff SHALL become the 10's-complement magnitude, neg=1, bout stays 1, and latency SHALL be 9 edges.
REQ-029 With the macro defined and bout=0, NEG SHALL be skipped and neg=0.
REQ-030 Without BCD_SUB_MAGNITUDE_EN: no NEG state; diff is the raw 10's-complement result; neg SHALL be tied 0.

Verification
REQ-031 a=5678, b=1234, bin=0, start -> after 5 edges done=1, diff=4444, bout=0, neg=0, err=0.
REQ-032 a=1000, b=0001, bin=0 -> diff=0999, bout=0; the borrow ripples through 3 digits.
REQ-033 a=0000, b=0001, bin=0 -> without macro diff=9999, bout=1, neg=0; with macro after 9 edges diff=0001, bout=1, neg=1.
REQ-034 a=9999, b=9999, bin=1 -> without macro diff=9999, bout=1; with macro diff=0001, neg=1.
REQ-035 Start a=5678, b=1234; pulse start again with a=0000 at the second SUB cycle -> second start ignored, result 4444; a=00A0 -> err=1.
REQ-036 Assert rst_n=0 during the third SUB cycle -> all outputs 0 immediately; a new start after release yields a correct result with 5-edge latency.

Source files
------------

// File: rtl/bcd_subtractor_4digits_seq_if.sv
// Handshake/data bundle for the sequential 4-digit BCD subtractor.
//   start, a, b, bin            : request side (driven by the master)
//   busy, done, diff, bout, neg, err : status/result side (driven by the slave)
interface bcd_subtractor_4digits_seq_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        neg;
    logic        err;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, neg, err
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, neg, err
    );
endinterface

// File: rtl/bcd_subtractor_4digits_seq.sv
// Sequential 4-digit packed-BCD subtractor, one digit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of bcd_subtractor_4digits_seq_if
//           start/a/b/bin in; busy/done/diff/bout/neg/err out (all registered)
// Optional feature macro: BCD_SUB_MAGNITUDE_EN
//   When defined, a negative result (bout=1) is converted to its magnitude
//   by an extra 4-cycle NEG pass computing 0000 - diff, and neg is set.
//   When undefined, diff is the raw 10's-complement result and neg stays 0.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SUB   | a - b - bin, one digit per cycle (digit 0 first)
// NEG   | 0000 - diff, one digit per cycle (magnitude build only)
// DONE  | one-cycle done pulse
module bcd_subtractor_4digits_seq (
    input  logic clk,
    input  logic rst_n,
    bcd_subtractor_4digits_seq_if.slave bus
);

`ifdef BCD_SUB_MAGNITUDE_EN
    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif

    state_t      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] diff_q;
    logic [1:0]  idx;
    logic        borrow;
    logic        bout_q;
    logic        neg_q;
    logic        err_q;
    logic        busy_q;
    logic        done_q;

    logic        in_neg;
    logic [3:0]  min_dig;
    logic [3:0]  sub_dig;
    logic [4:0]  t;
    logic        b_next;
    logic [3:0]  d_dig;

    function automatic logic has_bad_digit(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

`ifdef BCD_SUB_MAGNITUDE_EN
    assign in_neg = (state == NEG);
`else
    assign in_neg = 1'b0;
`endif

    // Shared digit datapath: SUB uses a_i - b_i, NEG uses 0 - diff_i.
    // t is 5-bit two's complement; its range -16..15 fits, so t[4] is the sign.
    always_comb begin
        min_dig = in_neg ? 4'd0 : a_q[{idx, 2'b00} +: 4];
        sub_dig = in_neg ? diff_q[{idx, 2'b00} +: 4] : b_q[{idx, 2'b00} +: 4];
        t       = {1'b0, min_dig} - {1'b0, sub_dig} - {4'b0000, borrow};
        b_next  = t[4];
        d_dig   = b_next ? 4'(t + 5'd10) : t[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= 16'h0000;
            b_q    <= 16'h0000;
            diff_q <= 16'h0000;
            idx    <= 2'd0;
            borrow <= 1'b0;
            bout_q <= 1'b0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        borrow <= bus.bin;
                        diff_q <= 16'h0000;
                        bout_q <= 1'b0;
                        neg_q  <= 1'b0;
                        idx    <= 2'd0;
                        err_q  <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
                        busy_q <= 1'b1;
                        state  <= SUB;
                    end
                end
                SUB: begin
                    diff_q[{idx, 2'b00} +: 4] <= d_dig;
                    borrow <= b_next;
                    idx    <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        bout_q <= b_next;
`ifdef BCD_SUB_MAGNITUDE_EN
                        if (b_next) begin
                            borrow <= 1'b0;
                            state  <= NEG;
                        end else begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
`else
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
`endif
                    end
                end
`ifdef BCD_SUB_MAGNITUDE_EN
                NEG: begin
                    diff_q[{idx, 2'b00} +: 4] <= d_dig;
                    borrow <= b_next;
                    idx    <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        neg_q  <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.neg  = neg_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_subtractor_4digits_seq.sv
// Self-checking bench for bcd_subtractor_4digits_seq: directed corner cases,
// an ignored-start case, mid-operation reset, then random operands checked
// against a decimal-arithmetic reference model.
module tb_bcd_subtractor_4digits_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bcd_subtractor_4digits_seq_if bus ();

    bcd_subtractor_4digits_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int x);
        logic [15:0] r;
        r[15:12] = 4'((x / 1000) % 10);
        r[11:8]  = 4'((x / 100) % 10);
        r[7:4]   = 4'((x / 10) % 10);
        r[3:0]   = 4'(x % 10);
        return r;
    endfunction

    function automatic logic any_bad(input logic [15:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    // Digit rule applied literally; only needed when some digit is not valid BCD.
    function automatic void digit_sub(input logic [15:0] m, input logic [15:0] s, input int bi,
                                      output logic [15:0] d, output logic bo);
        int br;
        int x;
        br = bi;
        d  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            x = int'(m[i*4 +: 4]) - int'(s[i*4 +: 4]) - br;
            if (x < 0) begin
                x  = x + 10;
                br = 1;
            end else begin
                br = 0;
            end
            d[i*4 +: 4] = 4'(x);
        end
        bo = (br != 0);
    endfunction

    function automatic void ref_model(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                                      output logic [15:0] d, output logic bo,
                                      output logic ng, output logic er);
        int          x;
        int          raw;
        logic [15:0] tmp;
        logic        dummy;
        er = any_bad(av) | any_bad(bv);
        ng = 1'b0;
        if (!er) begin
            x   = bcd2int(av) - bcd2int(bv) - int'(bi);
            bo  = (x < 0);
            raw = (x + 10000) % 10000;
            d   = int2bcd(raw);
`ifdef BCD_SUB_MAGNITUDE_EN
            if (bo) begin
                d  = int2bcd((10000 - raw) % 10000);
                ng = 1'b1;
            end
`endif
        end else begin
            digit_sub(av, bv, int'(bi), d, bo);
`ifdef BCD_SUB_MAGNITUDE_EN
            if (bo) begin
                tmp = d;
                digit_sub(16'h0000, tmp, 0, d, dummy);
                ng = 1'b1;
            end
`endif
        end
    endfunction

    function automatic int exp_latency(input logic bo);
`ifdef BCD_SUB_MAGNITUDE_EN
        return bo ? 9 : 5;
`else
        return 5;
`endif
    endfunction

    // Waits for done (bounded) and returns the number of edges after the start edge.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] ed, input logic eb,
                                input logic en, input logic ee);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
        check({tag, "_neg"},  32'(bus.neg),  32'(en));
        check({tag, "_err"},  32'(bus.err),  32'(ee));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic bi);
        logic [15:0] ed;
        logic        eb;
        logic        en;
        logic        ee;
        int          n;
        ref_model(av, bv, bi, ed, eb, en, ee);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = bi;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.bin   = 1'($urandom);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        check({tag, "_latency"}, 32'(n + 1), 32'(exp_latency(eb)));
        check_result(tag, ed, eb, en, ee);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, 32'(bus.diff), 32'(ed));
    endtask

    initial begin
        int          n;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] ed;
        logic        eb;
        logic        en;
        logic        ee;

        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        bus.bin   = 1'b0;
        rst_n     = 1'b0;
        #23;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_neg",  32'(bus.neg),  32'd0);
        check("rst_err",  32'(bus.err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic",  16'h5678, 16'h1234, 1'b0);
        run_op("ripple", 16'h1000, 16'h0001, 1'b0);
        run_op("under",  16'h0000, 16'h0001, 1'b0);
        run_op("all9",   16'h9999, 16'h9999, 1'b1);
        run_op("bad",    16'h00A0, 16'h0000, 1'b0);
        run_op("zero",   16'h0000, 16'h0000, 1'b1);

        // Second start during the second SUB cycle must be ignored.
        ref_model(16'h5678, 16'h1234, 1'b0, ed, eb, en, ee);
        @(negedge clk);
        bus.a = 16'h5678; bus.b = 16'h1234; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.a = 16'h0000; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 2;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ignore_latency", 32'(n + 1), 32'd5);
        check_result("ignore", ed, eb, en, ee);
        @(posedge clk);
        #1;
        check("ignore_no_requeue", 32'(bus.busy), 32'd0);

        // Reset asserted in the third SUB cycle discards the partial result.
        @(negedge clk);
        bus.a = 16'h5678; bus.b = 16'h1234; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_bout", 32'(bus.bout), 32'd0);
        check("midrst_err",  32'(bus.err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 16'h4321, 16'h1234, 1'b1);

        for (int it = 0; it < 24; it++) begin
            if (it % 6 == 5) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
            end else begin
                for (int d = 0; d < 4; d++) begin
                    ra[d*4 +: 4] = 4'($urandom_range(0, 9));
                    rb[d*4 +: 4] = 4'($urandom_range(0, 9));
                end
            end
            run_op($sformatf("rnd%0d", it), ra, rb, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
